// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- instruction fetch/issue stage.
//
// Owns the program counter, reads program memory through a one-cycle
// request / data-valid interface and hands one 8-bit instruction at a time
// to the control unit over a valid/ready handshake.  Instruction layout:
// [7:5] opcode, [4:0] register/immediate field.  A branch opcode parks the
// stage until the datapath resolves the branch, then the PC is redirected.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   halt        in   1  blocks the start of a new fetch
//   imem_req    out  1  one-cycle read request to program memory
//   imem_addr   out  8  read address (always equal to pc)
//   imem_rdata  in   8  read data, taken only while waiting for memory
//   imem_valid  in   1  read data valid
//   instr       out  8  instruction presented to decode
//   instr_valid out  1  instr holds an unconsumed instruction
//   instr_ready in   1  decode accepts instr this cycle
//   br_resolve  in   1  branch outcome valid
//   br_taken    in   1  branch outcome (taken when high)
//   pc          out  8  current program counter
//   retry       out  1  pulses in the cycle a timed-out request is reissued
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [7:0]  RESET_PC   = 8'h00,
    parameter logic [2:0]  OPC_BRANCH = 3'b100,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    input  logic       imem_valid,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       br_resolve,
    input  logic       br_taken,
    output logic [7:0] pc,
    output logic       retry
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_MEM = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_BR  = 3'd4;

    // Last wait count before the request is abandoned and reissued.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Sign-extend the 5-bit branch offset to PC width (-16..+15).
    function automatic logic [7:0] sext5(input logic [4:0] off);
        return {{3{off[4]}}, off};
    endfunction

    logic [2:0] state_r, state_s;
    logic [7:0] pc_r, pc_s;
    logic [7:0] instr_r, instr_s;
    logic       instr_valid_r, instr_valid_s;
    logic       imem_req_r, imem_req_s;
    logic       retry_r, retry_s;
    logic [7:0] cnt_r, cnt_s;

    // Next-state and next-output computation for the fetch/issue FSM.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instr_s       = instr_r;
        instr_valid_s = instr_valid_r;
        cnt_s         = cnt_r;
        retry_s       = 1'b0;
        imem_req_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!halt) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                cnt_s   = 8'd0;
                state_s = ST_WAIT_MEM;
            end

            ST_WAIT_MEM: begin
                if (imem_valid) begin
                    instr_s       = imem_rdata;
                    instr_valid_s = 1'b1;
                    state_s       = ST_ISSUE;
                end else if (cnt_r == CNT_LAST) begin
                    // Give up on this response; reissue the same address.
                    retry_s = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end

            ST_ISSUE: begin
                if (instr_valid_r && instr_ready) begin
                    instr_valid_s = 1'b0;
                    if (instr_r[7:5] == OPC_BRANCH) begin
                        // PC stays on the branch until the outcome arrives.
                        state_s = ST_WAIT_BR;
                    end else begin
                        pc_s = pc_r + 8'd1;
                        if (halt) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_FETCH;
                        end
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end

            ST_WAIT_BR: begin
                if (br_resolve) begin
                    if (br_taken) begin
                        pc_s = pc_r + sext5(instr_r[4:0]);
                    end else begin
                        pc_s = pc_r + 8'd1;
                    end
                    if (halt) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_WAIT_BR;
                end
            end

            default: begin
                state_s       = ST_IDLE;
                instr_valid_s = 1'b0;
                cnt_s         = 8'd0;
            end
        endcase

        // The request is high for exactly the cycle spent in FETCH; FETCH
        // always exits after one cycle, so entering it is the trigger.
        imem_req_s = (state_s == ST_FETCH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= 8'h00;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b0;
            retry_r       <= 1'b0;
            cnt_r         <= 8'd0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_valid_r <= instr_valid_s;
            imem_req_r    <= imem_req_s;
            retry_r       <= retry_s;
            cnt_r         <= cnt_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign retry       = retry_r;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch/issue stage. It is the producing end of the 8-bit instruction bus that the control unit decodes: [7:5] is the opcode and [4:0] is the register/immediate field. The block owns the program counter, reads program memory through a request/valid interface, and presents one instruction at a time to decode with a valid/ready handshake. It stalls on branch opcodes until the datapath resolves the branch, then redirects the PC.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
OPC_BRANCH, 3'b100, opcode in instr[7:5] that triggers branch wait
TIMEOUT, 15, WAIT_MEM cycles without imem_valid before the request is reissued (range 1..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
halt  input  1  when high, no new fetch is started
imem_req  output  1  one-cycle read request to program memory
imem_addr  output  8  read address; equals pc
imem_rdata  input  8  read data, sampled only when imem_valid=1 in WAIT_MEM
imem_valid  input  1  read data valid
instr  output  8  instruction to control unit
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decode accepts instr this cycle
br_resolve  input  1  datapath branch outcome valid
br_taken  input  1  branch outcome; meaningful with br_resolve
pc  output  8  current program counter
retry  output  1  one-cycle pulse when a memory request is reissued on timeout

Behaviour:
- Reset (rst_n low, asynchronous, any state): pc=RESET_PC, state=IDLE, imem_req=0, instr=8'h00, instr_valid=0, retry=0, timeout counter=0.
- imem_addr is always equal to pc, combinationally.
- States: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_BR.
- IDLE: outputs quiet. Go to FETCH when halt=0; otherwise stay in IDLE.
- FETCH: imem_req=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_MEM.
- WAIT_MEM: imem_req=0.
  - If imem_valid=1: instr<=imem_rdata, instr_valid<=1, go to ISSUE.
  - Else the counter increments. When counter==TIMEOUT-1 and imem_valid=0: pulse retry for one cycle, go to FETCH (same pc).
- ISSUE: instr and instr_valid are held stable until the cycle where instr_valid & instr_ready. On that accept edge, instr_valid<=0, and:
  - If instr[7:5]==OPC_BRANCH: pc unchanged, go to WAIT_BR.
  - Otherwise: pc<=pc+1, then go to IDLE if halt=1, else FETCH.
- WAIT_BR: on br_resolve=1:
  - Taken (br_taken=1): pc<=pc+sext(instr[4:0]), a signed 5-bit offset in the range -16..+15.
  - Not taken: pc<=pc+1.
  - Then go to IDLE if halt=1, else FETCH.
  - instr keeps the last value; instr_valid stays 0.
- Arithmetic: all pc updates are modulo 256. 8'hFF+1 gives 8'h00. 8'h02+sext(5'b10000) gives 8'hF2.
- Latency: the FETCH cycle is cycle 0. imem_valid seen in the cycle after (cycle 1) gives instr_valid=1 in cycle 2. Best-case throughput is one instruction per 3 cycles.
- Ignored events:
  - imem_valid outside WAIT_MEM, including a late response after a retry, is ignored.
  - br_resolve outside WAIT_BR is ignored.
  - instr_ready while instr_valid=0 has no effect.
- Timing of halt: halt is sampled only at the IDLE decision and at exit from ISSUE/WAIT_BR. Raising halt never aborts an outstanding request or a held instruction.
- Reset asserted mid-request or mid-handshake discards everything. The first request after reset release uses RESET_PC.

Test Plan:
- Linear fetch: memory returns 8'h20,8'h41,8'h62 at addresses 0,1,2 with one-cycle latency, instr_ready=1 -> instr sequence 20,41,62; imem_req pulses every 3 cycles; pc goes 0,1,2,3.
- Backpressure: instr_ready=0 for 5 cycles while instr=8'h41 is valid -> instr and instr_valid stable for all 5 cycles; no new imem_req; pc stays 1 until the accept edge.
- Branch: pc=8'h05, instr=8'h9D (opcode 100, offset -3). Accept it, hold br_resolve low 4 cycles, then br_resolve=1, br_taken=1 -> pc=8'h02 and the next imem_req uses addr 02. Repeat with br_taken=0 -> pc=8'h06.
- Wrap: pc=8'hFF, non-branch accepted -> pc=8'h00. Branch at pc=8'hFE with offset +15 (8'h8F) taken -> pc=8'h0D.
- Timeout: no imem_valid for TIMEOUT=15 cycles -> retry pulses once, imem_req reasserted with the same addr. A late imem_valid in FETCH is ignored; valid in the following WAIT_MEM loads instr.
- Reset/halt: assert rst_n=0 in WAIT_BR -> all outputs go to reset values immediately. After release with halt=1, the block stays in IDLE with no imem_req; dropping halt gives imem_req with addr=RESET_PC on the next cycle.
